// File: rtl/transform_sched_pkg.sv
// Shared types and sizes for the forward-transform scheduler.
// Imported by the scheduler top and its arbiter.
package transform_sched_pkg;

    localparam int unsigned N_COEF    = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DEF_IN_W  = 9;
    localparam int unsigned DEF_OUT_W = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Two-input round-robin arbiter. Combinational grant; the pointer only advances
// when the owner commits the grant via in_update.
module sched_rr_arbiter (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [1:0] in_req,
    input  logic       in_update,
    output logic [1:0] out_gnt
);

    // Index of the requester preferred when both are asserting.
    logic r_ptr;

    always_comb begin
        out_gnt = 2'b00;
        unique case (in_req)
            2'b01:   out_gnt = 2'b01;
            2'b10:   out_gnt = 2'b10;
            2'b11:   out_gnt = r_ptr ? 2'b10 : 2'b01;
            default: out_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_ptr <= 1'b0;
        end else if (in_update && (out_gnt != 2'b00)) begin
            // Favour whichever requester did not just win.
            r_ptr <= out_gnt[0];
        end
    end

endmodule

// File: rtl/transform_scheduler.sv
// Shares the 4x4 forward-transform datapath between two requesters: arbitrate,
// collect 16 samples, start the datapath, watch for done, stream 16 coefficients back.
module transform_scheduler
    import transform_sched_pkg::*;
#(
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned OUT_W   = DEF_OUT_W,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic [1:0]                in_req,
    output logic [1:0]                out_gnt,
    input  logic                      in_sample_valid,
    input  logic [IN_W-1:0]           in_sample,
    output logic                      out_sample_ready,
    output logic                      out_dp_start,
    output logic [N_COEF*IN_W-1:0]    out_X,
    input  logic [N_COEF*OUT_W-1:0]   in_T,
    input  logic                      in_dp_done,
    output logic                      out_res_valid,
    output logic [OUT_W-1:0]          out_res,
    output logic                      out_res_id,
    output logic                      out_res_last,
    input  logic                      in_res_ready,
    output logic                      out_busy,
    output logic                      out_timeout_err
);

    localparam int unsigned       WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_COEF - 1);

    sched_state_e      r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [1:0]        r_gnt, w_gnt_d;
    logic [WD_W-1:0]   r_wdog, w_wdog_d;
    logic              r_done_q;
    logic              r_timeout_err, w_timeout_err_d;
    logic [IN_W-1:0]   r_x [N_COEF];
    logic [OUT_W-1:0]  w_coef [N_COEF];
    logic [1:0]        w_arb_gnt;
    logic              w_arb_update;
    logic              w_x_we;
    logic              w_done_rise;

    sched_rr_arbiter u_arb (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_req    (in_req),
        .in_update (w_arb_update),
        .out_gnt   (w_arb_gnt)
    );

    // Only a rising edge of done counts, so a level held over from a prior block is ignored.
    assign w_done_rise = in_dp_done & ~r_done_q;

    always_comb begin
        for (int unsigned k = 0; k < N_COEF; k++) begin
            out_X[k*IN_W +: IN_W] = r_x[k];
            w_coef[k]             = in_T[k*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = r_cnt;
        w_gnt_d          = r_gnt;
        w_wdog_d         = r_wdog;
        w_timeout_err_d  = r_timeout_err;
        w_arb_update     = 1'b0;
        w_x_we           = 1'b0;
        out_sample_ready = 1'b0;
        out_dp_start     = 1'b0;
        out_res_valid    = 1'b0;
        out_res_last     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_arb_gnt != 2'b00) begin
                    w_arb_update = 1'b1;
                    w_gnt_d      = w_arb_gnt;
                    w_cnt_d      = '0;
                    w_state_d    = LOAD;
                end
            end
            LOAD: begin
                out_sample_ready = 1'b1;
                if (in_sample_valid) begin
                    w_x_we  = 1'b1;
                    w_cnt_d = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = START;
                    end
                end
            end
            START: begin
                out_dp_start = 1'b1;
                w_wdog_d     = '0;
                w_state_d    = WAIT;
            end
            WAIT: begin
                if (w_done_rise) begin
                    w_cnt_d   = '0;
                    w_state_d = DRAIN;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout_err_d = 1'b1;
                    w_gnt_d         = 2'b00;
                    w_state_d       = IDLE;
                end else begin
                    w_wdog_d = r_wdog + 1'b1;
                end
            end
            DRAIN: begin
                out_res_valid = 1'b1;
                out_res_last  = (r_cnt == CNT_LAST);
                if (in_res_ready) begin
                    w_cnt_d = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_gnt_d   = 2'b00;
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_gnt_d   = 2'b00;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_gnt         <= 2'b00;
            r_wdog        <= '0;
            r_done_q      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_gnt         <= w_gnt_d;
            r_wdog        <= w_wdog_d;
            r_done_q      <= in_dp_done;
            r_timeout_err <= w_timeout_err_d;
        end
    end

    // Sample store is only written in LOAD, so it stays stable while the datapath reads it.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int unsigned k = 0; k < N_COEF; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_x_we) begin
            r_x[r_cnt] <= in_sample;
        end
    end

    assign out_gnt         = r_gnt;
    assign out_res         = w_coef[r_cnt];
    assign out_res_id      = r_gnt[1];
    assign out_busy        = (r_state != IDLE);
    assign out_timeout_err = r_timeout_err;

endmodule
